// File: rtl/elevador_fila_param.sv
`default_nettype none
// ============================================================================
// Module      : elevador_fila_param
// Description : Parametrised cargo-lift core. Operator requests
//               {origem, destino} are edge-detected, validated and queued in a
//               circular FIFO. They are then served in arrival order:
//               drive to origin, open door, drive to destination, open door.
// Revision    : 1.0 - initial release
// ============================================================================
module elevador_fila_param #(
    parameter int N_ANDARES   = 16,
    parameter int DEPTH       = 4,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic [$clog2(N_ANDARES)-1:0]   origem,
    input  logic [$clog2(N_ANDARES)-1:0]   destino,
    input  logic                           novaEntrada,
    output logic [$clog2(N_ANDARES)-1:0]   andarAtual,
    output logic                           portaAberta,
    output logic                           subindo,
    output logic                           descendo,
    output logic                           ocupado,
    output logic                           vazio,
    output logic                           cheio,
    output logic [$clog2(DEPTH+1)-1:0]     contagem,
    output logic                           erro,
    output logic [2:0]                     dbEstado
);

    localparam int FW   = $clog2(N_ANDARES);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    // One shared timer serves both the per-floor step and the door hold.
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] C_MOVE_LAST = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] C_DOOR_LAST = TW'(DOOR_CYCLES - 1);
    localparam logic [FW:0]   C_NFLOORS   = (FW + 1)'(N_ANDARES);
    localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_MOVE_ORIGEM   = 3'd1,
        S_PORTA_ORIGEM  = 3'd2,
        S_MOVE_DESTINO  = 3'd3,
        S_PORTA_DESTINO = 3'd4
    } estado_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                novaEntrada_q;
    logic [2*FW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                erro_q;

    estado_t             state_q;
    logic [FW-1:0]       andar_q;
    logic [FW-1:0]       alvoO_q;
    logic [FW-1:0]       alvoD_q;
    logic [TW-1:0]       cnt_q;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                borda;
    logic                fila_vazia;
    logic                fila_cheia;
    logic                pop;
    logic                fora_faixa;
    logic                invalida;
    logic                push;
    logic                rejeita;
    logic                em_move;
    logic [FW-1:0]       alvo;

    assign borda      = novaEntrada && !novaEntrada_q;
    assign fila_vazia = (count_q == '0);
    assign fila_cheia = (count_q == C_DEPTH);
    // Dequeue only happens from IDLE; it frees a slot on the same edge,
    // so a push into a full queue is still accepted when it coincides.
    assign pop        = (state_q == S_IDLE) && iniciar && !fila_vazia;
    // Widened compare so floors beyond N_ANDARES are caught even when the
    // floor count is not a power of two.
    assign fora_faixa = ({1'b0, origem}  >= C_NFLOORS) ||
                        ({1'b0, destino} >= C_NFLOORS);
    assign invalida   = fora_faixa || (origem == destino) || (fila_cheia && !pop);
    assign push       = borda && !invalida;
    assign rejeita    = borda && invalida;

    assign alvo       = (state_q == S_MOVE_ORIGEM) ? alvoO_q : alvoD_q;
    assign em_move    = ((state_q == S_MOVE_ORIGEM) || (state_q == S_MOVE_DESTINO)) &&
                        (andar_q != alvo);

    // Status outputs decoded purely from registers
    assign andarAtual  = andar_q;
    assign portaAberta = (state_q == S_PORTA_ORIGEM) || (state_q == S_PORTA_DESTINO);
    assign subindo     = em_move && (alvo > andar_q);
    assign descendo    = em_move && (alvo < andar_q);
    assign ocupado     = (state_q != S_IDLE);
    assign vazio       = fila_vazia;
    assign cheio       = fila_cheia;
    assign contagem    = count_q;
    assign erro        = erro_q;
    assign dbEstado    = state_q;

    // Entry edge detection, request FIFO and rejection pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            novaEntrada_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            erro_q        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            novaEntrada_q <= novaEntrada;
            erro_q        <= rejeita;
            if (push) begin
                mem_q[wr_ptr_q] <= {origem, destino};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Service FSM: travel to origin, door, travel to destination, door
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            andar_q <= '0;
            alvoO_q <= '0;
            alvoD_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        {alvoO_q, alvoD_q} <= mem_q[rd_ptr_q];
                        cnt_q              <= '0;
                        state_q            <= S_MOVE_ORIGEM;
                    end
                end
                S_MOVE_ORIGEM, S_MOVE_DESTINO: begin
                    if (andar_q == alvo) begin
                        // Arrival is recognised one cycle after the last step
                        cnt_q   <= '0;
                        state_q <= (state_q == S_MOVE_ORIGEM) ? S_PORTA_ORIGEM
                                                              : S_PORTA_DESTINO;
                    end else if (cnt_q == C_MOVE_LAST) begin
                        cnt_q   <= '0;
                        andar_q <= (alvo > andar_q) ? andar_q + FW'(1)
                                                    : andar_q - FW'(1);
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                S_PORTA_ORIGEM, S_PORTA_DESTINO: begin
                    if (cnt_q == C_DOOR_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (state_q == S_PORTA_ORIGEM) ? S_MOVE_DESTINO
                                                               : S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
